trail_grid: RTL and testbench
=============================

// Module: trail_grid
// PURPOSE
//  Parametrised light-trail board for N players; replaces per-player flat trace registers.
//  Keeps one owner code per grid cell in a dual-port memory.
//  On each game tick it checks every live head against the pre-tick board, walls and the
//  other heads. It then writes the surviving heads into the board.
//  A render read port lets the pixel pipeline fetch the owner of any cell.
// PARAMETERS
//  GRID_W      100  board width in cells
//  GRID_H      100  board height in cells
//  NUM_PLAYERS 2    number of players (1..7)
//  XW = $clog2(GRID_W), YW = $clog2(GRID_H), PW = $clog2(NUM_PLAYERS+1)  (derived localparams)
// PORTS
//  clock      in   1               system clock
//  reset      in   1               async, active-high
//  clear      in   1               pulse: wipe board, clear crash flags
//  tick       in   1               pulse: process one move of all players
//  head_x     in   NUM_PLAYERS*XW  per-player head x, player p at [p*XW +: XW]
//  head_y     in   NUM_PLAYERS*YW  per-player head y
//  alive_in   in   NUM_PLAYERS     player p takes part in this game
//  busy       out  1               clear or tick in progress
//  done       out  1               1-cycle pulse: tick processing finished
//  crashed    out  NUM_PLAYERS     sticky crash flag per player
//  rd_x       in   XW              render read cell x
//  rd_y       in   YW              render read cell y
//  rd_owner   out  PW              0 = empty, p+1 = trail of player p; 1-cycle latency
// BEHAVIOUR
//  Reset values: state=IDLE, busy=0, done=0, crashed=0, rd_owner=0.
//  Board contents are undefined until the first clear completes.
//  States: IDLE, CLEAR, CHK_RD, CHK_EV, WR, FIN.
//  IDLE:
//   - clear=1 -> CLEAR. clear wins over a simultaneous tick.
//   - else tick=1 -> CHK_RD with p=0 and head inputs latched.
//  CLEAR:
//   - Writes 0 to addresses 0..GRID_W*GRID_H-1, one per cycle (addr = y*GRID_W+x).
//   - Zeroes crashed on entry.
//   - Returns to IDLE after the last address; no done pulse.
//  CHK_RD(p) / CHK_EV(p): 2 cycles per player.
//   - Skip checks when player p is not active (alive_in[p]=0 or crashed[p]=1); the 2 cycles still elapse.
//   - Crash if head_x>=GRID_W or head_y>=GRID_H (wall). No memory read is issued.
//   - Crash if the read cell is nonzero (any trail, including its own).
//   - Crash if another active, not-yet-crashed player q has the same head: both p and q crash.
//  WR(p): 1 cycle per player. Writes code p+1 at the head of each active player not crashed this tick.
//  FIN: done=1 for one cycle, then IDLE.
//  Latency: tick accepted in cycle T -> done high in cycle T+3*NUM_PLAYERS+1.
//  crashed only sets during processing. The flags become visible at the latest by the done cycle.
//  busy=1 in every state except IDLE.
//  tick while busy: ignored, not queued.
//  clear while busy (any state): aborts the tick immediately and enters CLEAR. No done pulse; no further writes.
//  Render port: rd_owner <= mem[rd_y*GRID_W+rd_x] each cycle.
//   - Forced to 0 during CLEAR and for out-of-range rd_x/rd_y.
//   - Reads see writes from the previous cycle (no same-cycle bypass required).
//  Reset mid-operation: immediately IDLE; flags cleared; board contents kept but must be re-cleared.
// TESTING
//  1 Reset, clear -> busy high exactly GRID_W*GRID_H cycles; all rd_owner reads = 0.
//  2 P0 at (5,5), P1 at (90,90), tick -> done at T+7; rd(5,5)=1, rd(90,90)=2, crashed=00.
//  3 Tick P0 again at (5,5) -> crashed[0]=1; cell (5,5) still 1; later ticks skip P0, P1 still writes.
//  4 Both heads at (40,40) -> crashed=11; rd(40,40)=0. Head x=100 -> wall crash, no write.
//  5 Tick while busy ignored (one done only). Clear in CHK_EV -> no done, crashed=0, board zeroed.
//  6 NUM_PLAYERS=4, GRID 16x16: three-way head collision plus one survivor -> only the survivor's cell written.

Source files
------------

// File: rtl/trail_grid.sv
// -----------------------------------------------------------------------------
// trail_grid
//   Light-trail game board for NUM_PLAYERS players. The board stores one owner
//   code per cell (0 = empty, p+1 = trail of player p). It lives in a dual-port
//   memory: port A is the engine port (clear, tick check reads, trail writes)
//   and port B is the render read port.
//
//   A tick walks the players in order. Each player gets two check cycles:
//   CHK_RD issues the board read and CHK_EV evaluates the wall, trail and
//   head-on crash tests. The player then gets one write cycle (WR). FIN
//   raises done for a single cycle.
//
// Ports
//   clock, reset  system clock, async active-high reset
//   clear         pulse: wipe board and crash flags (aborts any tick)
//   tick          pulse: process one move of all players (ignored while busy)
//   head_x/head_y packed per-player head coordinates, player p at [p*W +: W]
//   alive_in      per-player participation mask
//   busy          high in every state except IDLE
//   done          one-cycle pulse at the end of a tick
//   crashed       sticky per-player crash flags
//   rd_x/rd_y     render read coordinates
//   rd_owner      owner code of the addressed cell, one cycle later
// -----------------------------------------------------------------------------
module trail_grid #(
  parameter int GRID_W      = 100,
  parameter int GRID_H      = 100,
  parameter int NUM_PLAYERS = 2,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H),
  localparam int PW = $clog2(NUM_PLAYERS + 1)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      tick,
  input  logic [NUM_PLAYERS*XW-1:0] head_x,
  input  logic [NUM_PLAYERS*YW-1:0] head_y,
  input  logic [NUM_PLAYERS-1:0]    alive_in,
  output logic                      busy,
  output logic                      done,
  output logic [NUM_PLAYERS-1:0]    crashed,
  input  logic [XW-1:0]             rd_x,
  input  logic [YW-1:0]             rd_y,
  output logic [PW-1:0]             rd_owner
);

  localparam int DEPTH = GRID_W * GRID_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_CHK_RD = 3'd2;
  localparam logic [2:0] S_CHK_EV = 3'd3;
  localparam logic [2:0] S_WR     = 3'd4;
  localparam logic [2:0] S_FIN    = 3'd5;

  function automatic logic [AW-1:0] cell_addr(input logic [XW-1:0] x,
                                              input logic [YW-1:0] y);
    return AW'(y) * AW'(GRID_W) + AW'(x);
  endfunction

  // One extra bit on the compare so a power-of-two dimension does not wrap to 0.
  function automatic logic in_grid(input logic [XW-1:0] x, input logic [YW-1:0] y);
    return ({1'b0, x} < (XW+1)'(GRID_W)) && ({1'b0, y} < (YW+1)'(GRID_H));
  endfunction

  logic [2:0]             state_q, state_d;
  logic [IW-1:0]          p_q, p_d;
  logic [AW-1:0]          clr_addr_q, clr_addr_d;
  logic [NUM_PLAYERS-1:0] crashed_q, crashed_d;
  logic [NUM_PLAYERS-1:0] alive_q;
  logic [XW-1:0]          hx_q [NUM_PLAYERS];
  logic [YW-1:0]          hy_q [NUM_PLAYERS];
  logic                   load_heads;

  logic [PW-1:0]          mem [DEPTH];
  logic [PW-1:0]          rdata_q;
  logic [PW-1:0]          rd_owner_q;
  logic                   mem_we, mem_re;
  logic [AW-1:0]          mem_waddr, mem_raddr;
  logic [PW-1:0]          mem_wdata;

  logic [XW-1:0]          cur_x;
  logic [YW-1:0]          cur_y;
  logic                   cur_in_grid, cur_active;
  logic [NUM_PLAYERS-1:0] hit_mask, self_mask;

  assign cur_x       = hx_q[p_q];
  assign cur_y       = hy_q[p_q];
  assign cur_in_grid = in_grid(cur_x, cur_y);
  assign cur_active  = alive_q[p_q] && !crashed_q[p_q];

  // Other live heads on the same cell as the current player; all of them crash.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hit_mask  = '0;
    self_mask = '0;
    self_mask[p_q] = 1'b1;
    for (int q = 0; q < NUM_PLAYERS; q++) begin
      hit_mask[q] = (q != int'(p_q)) && alive_q[q] && !crashed_q[q] &&
                    (hx_q[q] == cur_x) && (hy_q[q] == cur_y);
    end
  end

  always_comb begin
    state_d    = state_q;
    p_d        = p_q;
    clr_addr_d = clr_addr_q;
    crashed_d  = crashed_q;
    load_heads = 1'b0;
    mem_we     = 1'b0;
    mem_waddr  = '0;
    mem_wdata  = '0;
    mem_re     = 1'b0;
    mem_raddr  = '0;

    if (clear) begin
      // Clear wins in every state, including over a pending tick; the engine
      // port stays idle this cycle so an aborted tick leaves no late write.
      state_d    = S_CLEAR;
      clr_addr_d = '0;
      crashed_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            state_d    = S_CHK_RD;
            p_d        = '0;
            load_heads = 1'b1;
          end
        end
        S_CLEAR: begin
          mem_we    = 1'b1;
          mem_waddr = clr_addr_q;
          if (clr_addr_q == AW'(DEPTH - 1)) state_d = S_IDLE;
          else clr_addr_d = clr_addr_q + AW'(1);
        end
        S_CHK_RD: begin
          // Wall heads get no read; an out-of-grid address would alias.
          if (cur_active && cur_in_grid) begin
            mem_re    = 1'b1;
            mem_raddr = cell_addr(cur_x, cur_y);
          end
          state_d = S_CHK_EV;
        end
        S_CHK_EV: begin
          // Order matters: rdata_q is only meaningful when the head is in-grid.
          if (cur_active && (!cur_in_grid || (rdata_q != '0) || (|hit_mask)))
            crashed_d = crashed_q | hit_mask | self_mask;
          if (p_q == IW'(NUM_PLAYERS - 1)) begin
            state_d = S_WR;
            p_d     = '0;
          end else begin
            state_d = S_CHK_RD;
            p_d     = p_q + IW'(1);
          end
        end
        S_WR: begin
          if (cur_active) begin
            mem_we    = 1'b1;
            mem_waddr = cell_addr(cur_x, cur_y);
            mem_wdata = PW'(p_q) + PW'(1);
          end
          if (p_q == IW'(NUM_PLAYERS - 1)) state_d = S_FIN;
          else p_d = p_q + IW'(1);
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      p_q        <= '0;
      clr_addr_q <= '0;
      crashed_q  <= '0;
      alive_q    <= '0;
      rd_owner_q <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        hx_q[i] <= '0;
        hy_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      p_q        <= p_d;
      clr_addr_q <= clr_addr_d;
      crashed_q  <= crashed_d;
      if (load_heads) begin
        alive_q <= alive_in;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
          hx_q[i] <= head_x[i*XW +: XW];
          hy_q[i] <= head_y[i*YW +: YW];
        end
      end
      if (state_q != S_CLEAR && in_grid(rd_x, rd_y))
        rd_owner_q <= mem[cell_addr(rd_x, rd_y)];
      else
        rd_owner_q <= '0;
    end
  end

  // NOTE: the board array has no reset; it is a RAM and is initialised by the
  // clear sequence instead. Write enables derive from the reset-held state.
  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (mem_re) rdata_q <= mem[mem_raddr];
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = (state_q == S_FIN);
  assign crashed  = crashed_q;
  assign rd_owner = rd_owner_q;

endmodule

// File: tb/tb_trail_grid.sv
// -----------------------------------------------------------------------------
// tb_trail_grid
//   Bench for trail_grid. dut0 uses the default 100x100 board with 2 players.
//   dut1 uses a 16x16 board with 4 players. Inputs are driven on the falling
//   edge and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_trail_grid;

  localparam int W0 = 100, H0 = 100;
  localparam int W1 = 16,  H1 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // dut0 signals
  logic        clr0, tick0, busy0, done0;
  logic [13:0] hx0, hy0;
  logic [1:0]  alive0, crashed0, own0;
  logic [6:0]  rdx0, rdy0;
  // dut1 signals
  logic        clr1, tick1, busy1, done1;
  logic [15:0] hx1, hy1;
  logic [3:0]  alive1, crashed1, rdx1, rdy1;
  logic [2:0]  own1;

  trail_grid #(.GRID_W(W0), .GRID_H(H0), .NUM_PLAYERS(2)) dut0 (
    .clock(clk), .reset(rst), .clear(clr0), .tick(tick0),
    .head_x(hx0), .head_y(hy0), .alive_in(alive0),
    .busy(busy0), .done(done0), .crashed(crashed0),
    .rd_x(rdx0), .rd_y(rdy0), .rd_owner(own0));

  trail_grid #(.GRID_W(W1), .GRID_H(H1), .NUM_PLAYERS(4)) dut1 (
    .clock(clk), .reset(rst), .clear(clr1), .tick(tick1),
    .head_x(hx1), .head_y(hy1), .alive_in(alive1),
    .busy(busy1), .done(done1), .crashed(crashed1),
    .rd_x(rdx1), .rd_y(rdy1), .rd_owner(own1));

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit         do_clear;
    int         x0, y0, x1, y1;
    logic [1:0] alive;
    logic [1:0] exp_crashed;
    int         ax, ay, aexp;
    int         bx, by, bexp;
  } vec_t;

  vec_t vecs[8];

  // Pulse clear on dut0 and count the busy cycles that follow.
  task automatic do_clear0(input string name);
    int n;
    bit seen_done;
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    n = 0;
    seen_done = 1'b0;
    while (busy0 && n < W0*H0 + 20) begin
      if (done0) seen_done = 1'b1;
      n++;
      @(negedge clk);
    end
    check({name, " busy cycles"}, n, W0*H0);
    check({name, " no done"}, 32'(seen_done), 0);
    check({name, " crashed zero"}, 32'(crashed0), 0);
  endtask

  task automatic set_heads0(input int x0, input int y0, input int x1, input int y1,
                            input logic [1:0] alive);
    hx0    = {7'(x1), 7'(x0)};
    hy0    = {7'(y1), 7'(y0)};
    alive0 = alive;
  endtask

  // Tick dut0 and return the cycle offset at which done appeared.
  task automatic do_tick0(output int lat);
    tick0 = 1'b1;
    @(negedge clk);
    tick0 = 1'b0;
    lat = 1;
    while (!done0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
    check("done pulse width", 32'(done0), 0);
  endtask

  task automatic read0(input int x, input int y, input int exp, input string name);
    rdx0 = 7'(x);
    rdy0 = 7'(y);
    @(negedge clk);
    check(name, 32'(own0), exp);
  endtask

  task automatic read1(input int x, input int y, input int exp, input string name);
    rdx1 = 4'(x);
    rdy1 = 4'(y);
    @(negedge clk);
    check(name, 32'(own1), exp);
  endtask

  initial begin
    int lat, n, ndone;
    bit seen_done;

    //            clr  x0   y0   x1   y1  alive  crash  ax  ay  a   bx   by  b
    vecs[0] = '{1'b0,   5,   5,  90,  90, 2'b11, 2'b00,  5,  5, 1,  90,  90, 2};
    vecs[1] = '{1'b0,   5,   5,  91,  90, 2'b11, 2'b01,  5,  5, 1,  91,  90, 2};
    vecs[2] = '{1'b0,   6,   5,  92,  90, 2'b11, 2'b01,  6,  5, 0,  92,  90, 2};
    vecs[3] = '{1'b1,  40,  40,  40,  40, 2'b11, 2'b11, 40, 40, 0,  41,  40, 0};
    vecs[4] = '{1'b1, 100,   3,  10,  10, 2'b11, 2'b01, 10, 10, 2,  99,   3, 0};
    vecs[5] = '{1'b1,  20,  20,  20,  20, 2'b10, 2'b00, 20, 20, 2,  21,  20, 0};
    vecs[6] = '{1'b0,   1,   1,   1, 100, 2'b11, 2'b10,  1,  1, 1,   1,  99, 0};
    vecs[7] = '{1'b0,  20,  20,   2,   2, 2'b11, 2'b11, 20, 20, 2,   2,   2, 0};

    rst = 1'b1;
    clr0 = 1'b0; tick0 = 1'b0; hx0 = '0; hy0 = '0; alive0 = '0; rdx0 = '0; rdy0 = '0;
    clr1 = 1'b0; tick1 = 1'b0; hx1 = '0; hy1 = '0; alive1 = '0; rdx1 = '0; rdy1 = '0;
    #12;
    check("reset busy", 32'(busy0), 0);
    check("reset done", 32'(done0), 0);
    check("reset crashed", 32'(crashed0), 0);
    check("reset rd_owner", 32'(own0), 0);
    check("reset busy dut1", 32'(busy1), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Initial wipe and an empty board.
    do_clear0("initial clear");
    read0(0, 0, 0, "empty (0,0)");
    read0(99, 99, 0, "empty (99,99)");
    read0(50, 7, 0, "empty (50,7)");

    // Table of ticks, each optionally preceded by a clear.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_clear) do_clear0($sformatf("vec%0d clear", i));
      set_heads0(vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1, vecs[i].alive);
      do_tick0(lat);
      check($sformatf("vec%0d latency", i), lat, 7);
      check($sformatf("vec%0d crashed", i), 32'(crashed0), 32'(vecs[i].exp_crashed));
      read0(vecs[i].ax, vecs[i].ay, vecs[i].aexp, $sformatf("vec%0d cell a", i));
      read0(vecs[i].bx, vecs[i].by, vecs[i].bexp, $sformatf("vec%0d cell b", i));
    end
    read0(100, 5, 0, "out-of-range render read");

    // A tick issued while busy is dropped: exactly one done.
    set_heads0(30, 30, 31, 31, 2'b11);
    tick0 = 1'b1;
    @(negedge clk);
    tick0 = 1'b0;
    @(negedge clk);
    tick0 = 1'b1;
    @(negedge clk);
    tick0 = 1'b0;
    ndone = 0;
    for (int k = 0; k < 30; k++) begin
      if (done0) ndone++;
      @(negedge clk);
    end
    check("tick while busy done count", ndone, 1);

    // Clear during CHK_EV of player 0 aborts the tick.
    set_heads0(50, 50, 60, 60, 2'b11);
    tick0 = 1'b1;
    @(negedge clk);
    tick0 = 1'b0;
    @(negedge clk);
    do_clear0("abort clear");
    seen_done = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (done0) seen_done = 1'b1;
      @(negedge clk);
    end
    check("abort no late done", 32'(seen_done), 0);
    read0(20, 20, 0, "abort board (20,20)");
    read0(1, 1, 0, "abort board (1,1)");
    read0(50, 50, 0, "abort head not written");

    // Reset in the middle of a tick.
    set_heads0(30, 30, 30, 30, 2'b11);
    tick0 = 1'b1;
    @(negedge clk);
    tick0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid-tick crashed", 32'(crashed0), 32'(2'b11));
    rst = 1'b1;
    #1;
    check("mid reset busy", 32'(busy0), 0);
    check("mid reset crashed", 32'(crashed0), 0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (done0) seen_done = 1'b1;
      @(negedge clk);
    end
    check("mid reset no done", 32'(seen_done), 0);

    // Four players on 16x16: three-way head collision plus one survivor.
    clr1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0;
    n = 0;
    while (busy1 && n < W1*H1 + 20) begin
      n++;
      @(negedge clk);
    end
    check("dut1 clear busy cycles", n, W1*H1);
    hx1    = {4'd8, 4'd3, 4'd3, 4'd3};
    hy1    = {4'd9, 4'd3, 4'd3, 4'd3};
    alive1 = 4'b1111;
    tick1  = 1'b1;
    @(negedge clk);
    tick1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check("dut1 latency", lat, 13);
    check("dut1 crashed", 32'(crashed1), 32'(4'b0111));
    read1(3, 3, 0, "dut1 collision cell");
    read1(8, 9, 4, "dut1 survivor cell");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
